// File: rtl/check_dpa_pattern.sv
// Receive-side checker for the DPA training stream: filters frames by EtherType/MAC,
// verifies payload length and 0x00/0xFF run structure, and keeps saturating counters.
module check_dpa_pattern #(
  parameter int DATA_LENGTH = 8192,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [47:0]           local_mac,
  input  logic                  clear_counters,
  input  logic                  s_eth_hdr_valid,
  output logic                  s_eth_hdr_ready,
  input  logic [47:0]           s_eth_dest_mac,
  input  logic [47:0]           s_eth_src_mac,
  input  logic [15:0]           s_eth_type,
  input  logic [DATA_WIDTH-1:0] s_eth_payload_axis_tdata,
  input  logic                  s_eth_payload_axis_tvalid,
  output logic                  s_eth_payload_axis_tready,
  input  logic                  s_eth_payload_axis_tlast,
  input  logic                  s_eth_payload_axis_tuser,
  output logic                  status_valid,
  output logic [3:0]            status,
  output logic [31:0]           frame_ok_count,
  output logic [31:0]           frame_err_count,
  output logic [31:0]           drop_count
);

  localparam int CW = $clog2(DATA_LENGTH) + 1;
  localparam logic [CW-1:0] LEN = CW'(DATA_LENGTH);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_DROP, S_REPORT} state_t;

  state_t        state, state_next;
  logic [CW-1:0] beat_cnt, beat_cnt_next, cnt_inc;
  logic          run_val, run_val_next;
  logic [2:0]    run_len, run_len_next;
  logic          first_run, first_run_next;
  logic [3:0]    status_next;
  logic          ok_inc, err_inc, drop_inc;
  logic          sym_bad, hdr_match;
  logic          unused_src;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign unused_src = ^s_eth_src_mac;

  assign s_eth_hdr_ready           = (state == S_IDLE);
  assign s_eth_payload_axis_tready = (state == S_CHECK) || (state == S_DROP);
  assign status_valid              = (state == S_REPORT);

  assign hdr_match = (s_eth_type == 16'h88B5) &&
                     ((s_eth_dest_mac == local_mac) || (s_eth_dest_mac == 48'hFFFF_FFFF_FFFF));

  always_comb begin
    state_next     = state;
    beat_cnt_next  = beat_cnt;
    run_val_next   = run_val;
    run_len_next   = run_len;
    first_run_next = first_run;
    status_next    = status;
    ok_inc         = 1'b0;
    err_inc        = 1'b0;
    drop_inc       = 1'b0;
    cnt_inc        = (beat_cnt == '1) ? beat_cnt : beat_cnt + 1'b1;
    sym_bad        = (s_eth_payload_axis_tdata != '0) && (s_eth_payload_axis_tdata != '1);

    case (state)
      S_IDLE: begin
        if (s_eth_hdr_valid) begin
          status_next   = 4'b0000;
          beat_cnt_next = '0;
          state_next    = hdr_match ? S_CHECK : S_DROP;
        end
      end
      S_CHECK: begin
        if (s_eth_payload_axis_tvalid) begin
          beat_cnt_next = cnt_inc;
          // Once a bad symbol is seen, run bookkeeping is meaningless for this frame
          if (sym_bad) begin
            status_next[1] = 1'b1;
          end else if (!status[1]) begin
            if (beat_cnt == '0) begin
              run_val_next   = s_eth_payload_axis_tdata[0];
              run_len_next   = 3'd1;
              first_run_next = 1'b1;
            end else if (s_eth_payload_axis_tdata[0] == run_val) begin
              run_len_next = (run_len == 3'd7) ? run_len : run_len + 3'd1;
              if (run_len >= 3'd5) status_next[2] = 1'b1;
            end else begin
              if (!first_run && (run_len != 3'd5)) status_next[2] = 1'b1;
              run_val_next   = s_eth_payload_axis_tdata[0];
              run_len_next   = 3'd1;
              first_run_next = 1'b0;
            end
          end
          if (s_eth_payload_axis_tuser) status_next[3] = 1'b1;
          if ((cnt_inc > LEN) || (s_eth_payload_axis_tlast && (cnt_inc != LEN)))
            status_next[0] = 1'b1;
          if (s_eth_payload_axis_tlast) begin
            state_next = S_REPORT;
            ok_inc     = (status_next == 4'b0000);
            err_inc    = (status_next != 4'b0000);
          end
        end
      end
      S_DROP: begin
        if (s_eth_payload_axis_tvalid && s_eth_payload_axis_tlast) begin
          drop_inc   = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_REPORT: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      beat_cnt  <= '0;
      run_val   <= 1'b0;
      run_len   <= 3'd0;
      first_run <= 1'b0;
      status    <= 4'b0000;
    end else begin
      state     <= state_next;
      beat_cnt  <= beat_cnt_next;
      run_val   <= run_val_next;
      run_len   <= run_len_next;
      first_run <= first_run_next;
      status    <= status_next;
    end
  end

  // Counters: a clear request takes priority over a same-cycle increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_ok_count  <= 32'd0;
      frame_err_count <= 32'd0;
      drop_count      <= 32'd0;
    end else if (clear_counters) begin
      frame_ok_count  <= 32'd0;
      frame_err_count <= 32'd0;
      drop_count      <= 32'd0;
    end else begin
      if (ok_inc)   frame_ok_count  <= sat_inc(frame_ok_count);
      if (err_inc)  frame_err_count <= sat_inc(frame_err_count);
      if (drop_inc) drop_count      <= sat_inc(drop_count);
    end
  end

endmodule

// File: tb/tb_check_dpa_pattern.sv
// Bench for check_dpa_pattern: directed and randomized frames checked against a
// run-list reference model of the pattern rules.
module tb_check_dpa_pattern;

  localparam int DL = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [47:0] local_mac = 48'h02_00_00_00_00_01;
  logic        clear_counters = 1'b0;
  logic        s_eth_hdr_valid = 1'b0;
  logic        s_eth_hdr_ready;
  logic [47:0] s_eth_dest_mac = '0;
  logic [47:0] s_eth_src_mac = 48'h02_AA_BB_CC_DD_EE;
  logic [15:0] s_eth_type = '0;
  logic [7:0]  tdata = '0;
  logic        tvalid = 1'b0;
  logic        tready;
  logic        tlast = 1'b0;
  logic        tuser = 1'b0;
  logic        status_valid;
  logic [3:0]  status;
  logic [31:0] frame_ok_count, frame_err_count, drop_count;

  check_dpa_pattern #(.DATA_LENGTH(DL), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .local_mac(local_mac), .clear_counters(clear_counters),
    .s_eth_hdr_valid(s_eth_hdr_valid), .s_eth_hdr_ready(s_eth_hdr_ready),
    .s_eth_dest_mac(s_eth_dest_mac), .s_eth_src_mac(s_eth_src_mac), .s_eth_type(s_eth_type),
    .s_eth_payload_axis_tdata(tdata), .s_eth_payload_axis_tvalid(tvalid),
    .s_eth_payload_axis_tready(tready), .s_eth_payload_axis_tlast(tlast),
    .s_eth_payload_axis_tuser(tuser), .status_valid(status_valid), .status(status),
    .frame_ok_count(frame_ok_count), .frame_err_count(frame_err_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int m_ok = 0, m_err = 0, m_drop = 0;
  int sv_pulses = 0;

  logic [7:0] fr_data [64];
  logic       fr_user [64];
  int         fr_len;

  always @(posedge clk) if (status_valid) sv_pulses <= sv_pulses + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pattern of alternating 0x00/0xFF runs: first run 'first' long, then runs of 5
  task automatic build_pattern(input int first, input int total);
    logic v = 1'b0;
    int cnt = 0;
    int rl = first;
    fr_len = total;
    for (int i = 0; i < total; i++) begin
      fr_data[i] = v ? 8'hFF : 8'h00;
      fr_user[i] = 1'b0;
      cnt++;
      if (cnt == rl) begin
        v = ~v;
        cnt = 0;
        rl = 5;
      end
    end
  endtask

  function automatic logic [3:0] model_status();
    logic [3:0] st = 4'b0000;
    int bad = fr_len;
    int cur = 0;
    int runs[$];
    if (fr_len != DL) st[0] = 1'b1;
    for (int i = 0; i < fr_len; i++) begin
      if (fr_user[i]) st[3] = 1'b1;
      if (bad == fr_len && fr_data[i] != 8'h00 && fr_data[i] != 8'hFF) bad = i;
    end
    if (bad < fr_len) st[1] = 1'b1;
    for (int i = 0; i < bad; i++) begin
      if (i == 0 || fr_data[i] == fr_data[i-1]) cur++;
      else begin
        runs.push_back(cur);
        cur = 1;
      end
    end
    if (bad > 0) runs.push_back(cur);
    for (int k = 0; k < runs.size(); k++) begin
      if (runs[k] > 5) st[2] = 1'b1;
      if (k > 0 && k < runs.size() - 1 && runs[k] != 5) st[2] = 1'b1;
    end
    return st;
  endfunction

  task automatic send_frame(input logic [15:0] typ, input logic [47:0] dest,
                            input bit rnd, input bit is_check, input bit clr_last);
    logic [3:0] exp_st;
    bit accepted;
    bit all_ok = 1;
    int guard;
    int pulses0;
    exp_st = model_status();
    s_eth_type = typ;
    s_eth_dest_mac = dest;
    s_eth_hdr_valid = 1'b1;
    accepted = 0;
    guard = 0;
    while (!accepted && guard < 50) begin
      accepted = s_eth_hdr_ready;
      @(posedge clk); #1;
      guard++;
    end
    s_eth_hdr_valid = 1'b0;
    check("hdr_accept", 32'(accepted), 32'd1);
    check("tready_after_hdr", 32'(tready), 32'd1);
    pulses0 = sv_pulses;
    for (int i = 0; i < fr_len; i++) begin
      tdata = fr_data[i];
      tuser = fr_user[i];
      tlast = (i == fr_len - 1);
      if (clr_last && i == fr_len - 1) clear_counters = 1'b1;
      accepted = 0;
      guard = 0;
      while (!accepted && guard < 100) begin
        tvalid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        accepted = tvalid && tready;
        @(posedge clk); #1;
        guard++;
      end
      if (!accepted) all_ok = 0;
    end
    tvalid = 1'b0;
    tlast = 1'b0;
    tuser = 1'b0;
    clear_counters = 1'b0;
    check("beats_accepted", 32'(all_ok), 32'd1);
    if (clr_last) begin
      m_ok = 0; m_err = 0; m_drop = 0;
    end else if (!is_check) m_drop++;
    else if (exp_st == 4'b0000) m_ok++;
    else m_err++;
    if (is_check) begin
      check("status_valid_pulse", 32'(status_valid), 32'd1);
      check("status", 32'(status), 32'(exp_st));
      check("hdr_ready_in_report", 32'(s_eth_hdr_ready), 32'd0);
    end else begin
      check("drop_no_pulse", 32'(sv_pulses - pulses0), 32'd0);
      check("drop_status_cleared", 32'(status), 32'd0);
    end
    check("frame_ok_count", frame_ok_count, 32'(m_ok));
    check("frame_err_count", frame_err_count, 32'(m_err));
    check("drop_count", drop_count, 32'(m_drop));
    @(posedge clk); #1;
    check("status_valid_low", 32'(status_valid), 32'd0);
    check("hdr_ready_back", 32'(s_eth_hdr_ready), 32'd1);
    if (is_check) check("status_hold", 32'(status), 32'(exp_st));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hdr_ready"}, 32'(s_eth_hdr_ready), 32'd1);
    check({tag, "_tready"}, 32'(tready), 32'd0);
    check({tag, "_status_valid"}, 32'(status_valid), 32'd0);
    check({tag, "_status"}, 32'(status), 32'd0);
    check({tag, "_ok"}, frame_ok_count, 32'd0);
    check({tag, "_err"}, frame_err_count, 32'd0);
    check({tag, "_drop"}, drop_count, 32'd0);
  endtask

  initial begin
    int first, mode, idx, len;
    logic [47:0] dst;
    #2 rst = 1'b1;
    #2 check_reset_outputs("reset");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Nominal frame, continuous tvalid
    build_pattern(5, DL);
    send_frame(16'h88B5, local_mac, 0, 1, 0);
    // Phase-shifted frame, random tvalid gaps
    build_pattern(2, DL);
    send_frame(16'h88B5, local_mac, 1, 1, 0);
    // Symbol error on beat 7
    build_pattern(5, DL);
    fr_data[6] = 8'h0F;
    send_frame(16'h88B5, local_mac, 1, 1, 0);
    // Interior run of six 0xFF
    fr_len = DL;
    for (int i = 0; i < DL; i++) begin
      fr_data[i] = (i >= 5 && i <= 10) || i >= 16 ? 8'hFF : 8'h00;
      fr_user[i] = 1'b0;
    end
    send_frame(16'h88B5, local_mac, 0, 1, 0);
    // Short, long, and tuser frames
    build_pattern(5, 18);
    send_frame(16'h88B5, local_mac, 1, 1, 0);
    build_pattern(5, 22);
    send_frame(16'h88B5, local_mac, 1, 1, 0);
    build_pattern(5, DL);
    fr_user[DL-1] = 1'b1;
    send_frame(16'h88B5, 48'hFFFF_FFFF_FFFF, 0, 1, 0);
    // Filtered frames
    build_pattern(5, DL);
    send_frame(16'h0800, local_mac, 1, 0, 0);
    send_frame(16'h88B5, 48'h02_00_00_00_00_02, 1, 0, 0);

    // Randomized frames
    for (int r = 0; r < 10; r++) begin
      first = $urandom_range(1, 5);
      mode = $urandom_range(0, 3);
      len = (mode == 2) ? $urandom_range(14, 26) : DL;
      build_pattern(first, len);
      idx = $urandom_range(0, len - 1);
      if (mode == 1) fr_data[idx] = 8'($urandom_range(0, 255));
      if (mode == 3) fr_user[idx] = 1'b1;
      dst = $urandom_range(0, 1) ? local_mac : 48'hFFFF_FFFF_FFFF;
      send_frame(16'h88B5, dst, 1, 1, 0);
    end

    // Clear coinciding with the increment of the final beat
    build_pattern(3, DL);
    send_frame(16'h88B5, local_mac, 0, 1, 1);
    build_pattern(5, DL);
    send_frame(16'h0800, local_mac, 0, 0, 0);

    // Reset mid-frame after beat 9
    build_pattern(5, DL);
    s_eth_type = 16'h88B5;
    s_eth_dest_mac = local_mac;
    s_eth_hdr_valid = 1'b1;
    @(posedge clk); #1;
    s_eth_hdr_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tdata = fr_data[i];
      tvalid = 1'b1;
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1 check_reset_outputs("midreset");
    @(posedge clk); #1;
    rst = 1'b0;
    m_ok = 0; m_err = 0; m_drop = 0;
    for (int i = 9; i < 12; i++) begin
      tdata = fr_data[i];
      tvalid = 1'b1;
      @(posedge clk); #1;
      check("post_reset_tready", 32'(tready), 32'd0);
    end
    tvalid = 1'b0;
    check_reset_outputs("post_reset");
    build_pattern(5, DL);
    send_frame(16'h88B5, local_mac, 1, 1, 0);
    check("final_ok_count", frame_ok_count, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/check_dpa_pattern.md
# check_dpa_pattern

Receive-side checker for the DPA training stream produced by the transmit-side DPA pattern generator. It sits downstream of the Ethernet frame receiver and consumes its decoded header and AXI-stream payload. It filters frames by EtherType and destination MAC, and verifies payload length and the 0x00/0xFF run structure of the pattern. It reports per-frame status and keeps saturating frame counters for the link-bring-up logic.

## Interface
- DATA_LENGTH, 8192, payload beats expected per frame
- DATA_WIDTH, 8, payload width; must be 8
- clk  in  1  clock
- rst  in  1  reset. Asynchronous, active-high: assertion immediately forces every register to its reset value, independent of clk.
- local_mac  in  48  accepted destination MAC (ff:ff:ff:ff:ff:ff is also accepted)
- clear_counters  in  1  synchronous pulse that zeroes all counters
- s_eth_hdr_valid  in  1  header valid
- s_eth_hdr_ready  out  1  header ready
- s_eth_dest_mac  in  48  destination MAC
- s_eth_src_mac  in  48  source MAC (ignored)
- s_eth_type  in  16  EtherType
- s_eth_payload_axis_tdata  in  8  payload byte
- s_eth_payload_axis_tvalid  in  1  payload valid
- s_eth_payload_axis_tready  out  1  payload ready
- s_eth_payload_axis_tlast  in  1  last payload beat
- s_eth_payload_axis_tuser  in  1  frame error flag from the receiver
- status_valid  out  1  one-cycle pulse; status is valid
- status  out  4  [0] length error, [1] symbol error, [2] run error, [3] tuser error
- frame_ok_count  out  32  frames with status==0, saturating
- frame_err_count  out  32  checked frames with status!=0, saturating
- drop_count  out  32  filtered frames, saturating

## Operation
- States:
  - S_IDLE: s_eth_hdr_ready=1.
  - S_CHECK: tready=1; payload is checked.
  - S_DROP: tready=1; payload is discarded.
  - S_REPORT: one cycle, status_valid=1.
- Header handshake in S_IDLE:
  - s_eth_type==16'h88B5 and dest_mac matches (local_mac or broadcast) -> S_CHECK.
  - Otherwise -> S_DROP.
- S_DROP: on the beat with tlast, drop_count increments and the state returns to S_IDLE. No status pulse is issued.
- S_CHECK, per accepted beat:
  - Beat counter: width clog2(DATA_LENGTH)+1, saturating.
  - tdata not in {0x00, 0xFF} -> status[1] set. Run checks are suspended for the rest of the frame.
  - First beat of the frame: run_val = tdata[0], run_len = 1, first_run = 1.
  - Same value as run_val: run_len+1. If the result exceeds 5 -> status[2].
  - Value toggles: if first_run==0 and run_len!=5 -> status[2]. Then run_len = 1, first_run = 0.
  - The first and last runs of a frame may be 1..5 long; every interior run must be exactly 5.
  - Any beat with tuser=1 -> status[3].
- tlast beat: beat count including this beat != DATA_LENGTH -> status[0]. Then -> S_REPORT.
- Beats beyond DATA_LENGTH without tlast: status[0] is set and draining continues until tlast.
- S_REPORT -> S_IDLE unconditionally.
- Status bits are sticky within a frame and cleared on header acceptance.
- Counters saturate at 32'hFFFFFFFF. If clear_counters coincides with an increment, clear wins.

## Timing
- Reset values:
  - state S_IDLE
  - s_eth_hdr_ready=1, tready=0
  - status_valid=0, status=0
  - all counters 0
- hdr_ready and tready are decoded from the state register only; there is no combinational path from any input.
- After a header handshake, tready=1 on the next cycle.
- tlast accepted at edge N:
  - status and counters are updated at edge N.
  - status_valid is high for the cycle following edge N.
  - hdr_ready returns one cycle later.
- Minimum gap between frames is 2 cycles.
- status holds its value until the next header acceptance.
- rst asserted mid-frame: the partial frame is abandoned with no counter update. Remaining beats seen after reset are treated as idle until a header arrives.

## Test plan
- DATA_LENGTH=20, type 0x88B5, dest=local_mac, payload 00×5 FF×5 00×5 FF×5 with tlast on beat 20 -> status_valid one cycle, status=0, frame_ok_count=1.
- Phase-shifted payload 00×2 FF×5 00×5 FF×5 00×3, with tvalid toggled randomly -> status=0, frame_ok_count=2.
- Beat 7 = 0x0F -> status=4'b0010, frame_err_count=1. Separately, FF×6 in an interior run -> status=4'b0100.
- tlast on beat 18 -> status[0]. A 22-beat frame -> status[0]. A frame with tuser=1 on its last beat -> status[3].
- Type 0x0800, then a frame with a wrong dest MAC -> each payload fully drained, drop_count=2, no status_valid.
- rst pulsed at beat 9 -> all outputs return to reset values immediately, counters 0. The next good frame -> frame_ok_count=1.
